decoder_2x4_stream: RTL
=======================

DECODER_2X4_STREAM -- requirements
Module: decoder_2x4_stream

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  upstream word present.
REQ-004 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-005 SHALL have port: y  input  2  binary position code (encoder y output).
REQ-006 SHALL have port: v  input  1  code valid flag (encoder v output); 0 = upstream saw illegal pattern.
REQ-007 SHALL have port: out_valid  output  1  decoded word present.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts word.
REQ-009 SHALL have port: d  output  4  one-hot decode of y (y=00->0001, 01->0010, 10->0100, 11->1000).
REQ-010 SHALL have port: err  output  1  word carried v=0; d=0000 for that word.
REQ-011 SHALL have port: err_cnt  output  8  saturating count of accepted v=0 words (present only with DEC_ERR_CNT_EN).

Function
REQ-012 SHALL transfer input on cycle where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-013 SHALL register decode: accepted word visible on d/err/out_valid exactly 1 cycle after input transfer when buffer was empty.
REQ-014 SHALL decode v=1 words as one-hot per REQ-009 with err=0; v=0 words as d=0000, err=1, regardless of y.
REQ-015 SHALL buffer up to 2 words (output register + skid register); FSM states EMPTY, ONE, FULL.
REQ-016 SHALL transition: EMPTY->ONE on input transfer; ONE->FULL on input transfer without output transfer; ONE->EMPTY on output transfer without input transfer; ONE stays ONE on simultaneous transfers; FULL->ONE on output transfer.
REQ-017 SHALL drive in_ready as registered (state != FULL), no combinational path from out_ready to in_ready.
REQ-018 SHALL, in FULL on output transfer, move skid word to output register next cycle, preserving order.
REQ-019 SHALL hold d/err/out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL drop nothing and duplicate nothing: every accepted word delivered once, in order.
REQ-021 SHALL ignore y/v when in_valid=0 or in_ready=0.

Reset
REQ-022 SHALL on rst=1 at clock edge: state EMPTY, out_valid=0, in_ready=1, d=0000, err=0, err_cnt=0.
REQ-023 SHALL discard buffered words on reset mid-operation; no output transfer reported in reset cycle.
REQ-024 SHALL accept input the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with DEC_ERR_CNT_EN defined, provide err_cnt incrementing by 1 per accepted v=0 word, saturating at 255, cleared only by reset.
REQ-026 SHALL, without DEC_ERR_CNT_EN, omit err_cnt port and counter logic; all other behaviour identical.

Structure
REQ-027 SHALL place state enum (EMPTY/ONE/FULL), CODE_W=2, ONEHOT_W=4, ERR_CNT_W=8 in shared package decoder_pkg.
REQ-028 SHALL implement the combinational y/v -> d/err map in sub-module decoder_2x4_core, instantiated once ahead of the buffer.

Verification
REQ-029 SHALL cover: reset, then y=10,v=1, in_valid=1, out_ready=1 -> next cycle out_valid=1, d=0100, err=0.
REQ-030 SHALL cover: y=01,v=0 accepted -> d=0000, err=1, err_cnt 0->1 (macro on).
REQ-031 SHALL cover: out_ready=0, send 00 then 11 -> in_ready=0 after 2nd accept; out_ready=1 -> d=0001 then 1000 on consecutive cycles.
REQ-032 SHALL cover: continuous in_valid/out_ready=1 for 4 codes 00,01,10,11 -> 4 outputs back-to-back, 1 per cycle, in order.
REQ-033 SHALL cover: 300 accepted v=0 words -> err_cnt=255 and holds.
REQ-034 SHALL cover: rst asserted in FULL -> next cycle out_valid=0, in_ready=1, err_cnt=0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and widths for the 2-to-4 streaming decoder.
// Holds the buffer-occupancy enum and the decoded word layout.
// Optional error counter width is used only when DEC_ERR_CNT_EN is defined.
package decoder_pkg;

  localparam int CODE_W    = 2;
  localparam int ONEHOT_W  = 4;
  localparam int ERR_CNT_W = 8;

  // Occupancy of the two-entry buffer (output register + skid register)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // One decoded word as it sits in either buffer slot
  typedef struct packed {
    logic [ONEHOT_W-1:0] d;
    logic                err;
  } dec_word_t;

endpackage

// File: rtl/decoder_2x4_core.sv
// Combinational map from a 2-bit position code plus valid flag to a one-hot word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the surrounding buffer decides when the result is captured.
module decoder_2x4_core
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0]   y,
  input  logic                v,
  output logic [ONEHOT_W-1:0] d,
  output logic                err
);

  // A flagged-invalid code decodes to all zeros with err set, whatever y holds
  always_comb begin
    d   = '0;
    err = 1'b0;
    if (v) begin
      d[y] = 1'b1;
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_2x4_stream.sv
// Valid/ready wrapper around the 2-to-4 decoder with a two-entry (output + skid) buffer.
// Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
// Backpressure: in_ready is a flop (state != FULL); out_ready never reaches in_ready combinationally.
// Optional: define DEC_ERR_CNT_EN to add the saturating err_cnt output.
module decoder_2x4_stream
  import decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    y,
  input  logic                 v,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ONEHOT_W-1:0]  d,
  output logic                 err
`ifdef DEC_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_e    state_q, state_d;
  dec_word_t out_word_q, out_word_d;
  dec_word_t skid_word_q, skid_word_d;
  logic      in_ready_q, in_ready_d;
  dec_word_t dec_word;
  logic      in_xfer;
  logic      out_xfer;

  decoder_2x4_core u_core (
    .y   (y),
    .v   (v),
    .d   (dec_word.d),
    .err (dec_word.err)
  );

  assign in_xfer   = in_valid && in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_xfer  = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign d         = out_word_q.d;
  assign err       = out_word_q.err;

  // Buffer occupancy and slot contents; the skid slot only fills when the output slot is stuck
  always_comb begin
    state_d     = state_q;
    out_word_d  = out_word_q;
    skid_word_d = skid_word_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d    = ONE;
          out_word_d = dec_word;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          out_word_d = dec_word;
        end else if (in_xfer) begin
          state_d     = FULL;
          skid_word_d = dec_word;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move
        if (out_xfer) begin
          state_d    = ONE;
          out_word_d = skid_word_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    in_ready_d = (state_d != FULL);
  end

  // Registers for occupancy, both buffer slots and the registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_word_q  <= '0;
      skid_word_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_word_q  <= out_word_d;
      skid_word_q <= skid_word_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Count accepted invalid-code words, sticking at all ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_xfer && !v && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
